freq_sweep_sequencer: RTL and testbench

Autonomous sweep scheduler for the frequency counter control block. It takes a 32-bit channel mask and a sample count from the host. For each enabled input it programs the counter's input select and sample count, starts a measurement, waits for the completion interrupt, reads back the average and stores it in a per-channel result bank. It raises a single sweep-done interrupt, so the host does not have to hand-sequence every channel over the counter's register bus.

---
 rtl/freq_pkg.sv | 30 +++
 rtl/freq_next_channel.sv | 20 ++
 rtl/freq_sweep_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_freq_sweep_sequencer.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_pkg.sv
// Shared constants and types for the frequency sweep sequencer.
package freq_pkg;

  localparam int unsigned CH_W   = 5;
  localparam int unsigned AVG_W  = 10;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned SMP_W  = 10;
  localparam int unsigned MASK_W = 32;

  // Frequency counter register map
  localparam logic [ADDR_W-1:0] ADDR_SEL     = 6'h21;
  localparam logic [ADDR_W-1:0] ADDR_SAMPLES = 6'h22;
  localparam logic [ADDR_W-1:0] ADDR_START   = 6'h2F;
  localparam logic [ADDR_W-1:0] ADDR_AVG     = 6'h11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PICK,
    S_SET_SEL,
    S_SET_SMP,
    S_GO,
    S_WAIT,
    S_RB_REQ,
    S_RB_CAP,
    S_SETTLE,
    S_DONE
  } seq_state_e;

endpackage

// File: rtl/freq_next_channel.sv
// Lowest-set-bit priority encoder used to pick the next channel to measure.
module freq_next_channel
  import freq_pkg::*;
(
  input  logic [MASK_W-1:0] mask,
  output logic [CH_W-1:0]   idx,
  output logic              any
);

  // Scan from the top so the lowest set bit is the last one to win
  always_comb begin
    idx = '0;
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (mask[i]) idx = CH_W'(i);
    end
  end

  assign any = |mask;

endmodule

// File: rtl/freq_sweep_sequencer.sv
// Sweeps the enabled counter inputs one by one, storing each average in a
// per-channel result bank and raising one interrupt at the end of the sweep.
module freq_sweep_sequencer
  import freq_pkg::*;
#(
  parameter int unsigned N_CH           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned SETTLE_CYCLES  = 4
) (
  input  logic                Clock,
  input  logic                nReset,
  input  logic                host_start,
  input  logic                host_abort,
  input  logic [MASK_W-1:0]   host_mask,
  input  logic [SMP_W-1:0]    host_samples,
  output logic                busy,
  output logic                sweep_irq,
  input  logic                host_ack,
  input  logic [CH_W-1:0]     res_sel,
  output logic [AVG_W-1:0]    res_data,
  output logic [MASK_W-1:0]   res_valid,
  output logic [MASK_W-1:0]   res_timeout,
  output logic [ADDR_W-1:0]   cnt_addr,
  output logic [DATA_W-1:0]   cnt_wdata,
  output logic                cnt_cfg_wr,
  output logic                cnt_rd_req,
  input  logic [DATA_W-1:0]   cnt_rdata,
  input  logic                cnt_irq
);

  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned STL_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [STL_W-1:0] STL_LAST = STL_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  seq_state_e        state_q, state_d;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic [SMP_W-1:0]  samples_q, samples_d;
  logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [STL_W-1:0]  stl_q, stl_d;
  logic              tmo_flag_q, tmo_flag_d;
  logic              abort_q, abort_d;
  logic              busy_d, irq_d;
  logic [MASK_W-1:0] valid_d, timeout_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              cfg_wr_d, rd_req_d;
  logic              bank_we;
  logic [AVG_W-1:0]  bank_q [N_CH];

  logic [CH_W-1:0]   nxt_idx;
  logic              nxt_any;
  logic              unused_rdata;

  assign unused_rdata = ^cnt_rdata[DATA_W-1:AVG_W];

  freq_next_channel u_next (
    .mask (mask_q),
    .idx  (nxt_idx),
    .any  (nxt_any)
  );

  assign res_data = bank_q[res_sel];

  // Next-state and next-output logic; counter strobes are decoded from the
  // state being entered so they appear in the same cycle as that state.
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    samples_d  = samples_q;
    cur_ch_d   = cur_ch_q;
    tmo_d      = tmo_q;
    stl_d      = stl_q;
    tmo_flag_d = tmo_flag_q;
    abort_d    = abort_q;
    busy_d     = busy;
    irq_d      = sweep_irq & ~host_ack;
    valid_d    = res_valid;
    timeout_d  = res_timeout;
    addr_d     = cnt_addr;
    wdata_d    = cnt_wdata;
    cfg_wr_d   = 1'b0;
    rd_req_d   = 1'b0;
    bank_we    = 1'b0;

    if (state_q != S_IDLE && host_abort) abort_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (host_start) begin
          mask_d    = host_mask;
          samples_d = host_samples;
          valid_d   = '0;
          timeout_d = '0;
          abort_d   = 1'b0;
          busy_d    = 1'b1;
          state_d   = (|host_mask) ? S_PICK : S_DONE;
        end
      end
      S_PICK: begin
        if (host_abort || !nxt_any) begin
          state_d = S_DONE;
        end else begin
          cur_ch_d        = nxt_idx;
          mask_d[nxt_idx] = 1'b0;
          state_d         = S_SET_SEL;
        end
      end
      S_SET_SEL: state_d = host_abort ? S_DONE : S_SET_SMP;
      S_SET_SMP: state_d = host_abort ? S_DONE : S_GO;
      S_GO: begin
        tmo_d      = '0;
        tmo_flag_d = 1'b0;
        state_d    = host_abort ? S_RB_REQ : S_WAIT;
      end
      S_WAIT: begin
        if (host_abort || cnt_irq) begin
          state_d = S_RB_REQ;
        end else if (tmo_q == TMO_LAST) begin
          tmo_flag_d          = 1'b1;
          timeout_d[cur_ch_q] = 1'b1;
          state_d             = S_RB_REQ;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_RB_REQ: state_d = (host_abort || abort_q) ? S_DONE : S_RB_CAP;
      S_RB_CAP: begin
        if (host_abort) begin
          state_d = S_DONE;
        end else begin
          bank_we = 1'b1;
          if (!tmo_flag_q) valid_d[cur_ch_q] = 1'b1;
          stl_d   = '0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (host_abort) begin
          state_d = S_DONE;
        end else if (stl_q >= STL_LAST && !cnt_irq) begin
          state_d = S_PICK;
        end else if (stl_q < STL_LAST) begin
          stl_d = stl_q + STL_W'(1);
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        if (!(abort_q || host_abort)) irq_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_SET_SEL: begin
        cfg_wr_d = 1'b1;
        addr_d   = ADDR_SEL;
        wdata_d  = DATA_W'(cur_ch_d);
      end
      S_SET_SMP: begin
        cfg_wr_d = 1'b1;
        addr_d   = ADDR_SAMPLES;
        wdata_d  = DATA_W'(samples_d);
      end
      S_GO: begin
        cfg_wr_d = 1'b1;
        addr_d   = ADDR_START;
        wdata_d  = '0;
      end
      S_RB_REQ: begin
        rd_req_d = 1'b1;
        addr_d   = ADDR_AVG;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q     <= S_IDLE;
      mask_q      <= '0;
      samples_q   <= '0;
      cur_ch_q    <= '0;
      tmo_q       <= '0;
      stl_q       <= '0;
      tmo_flag_q  <= 1'b0;
      abort_q     <= 1'b0;
      busy        <= 1'b0;
      sweep_irq   <= 1'b0;
      res_valid   <= '0;
      res_timeout <= '0;
      cnt_addr    <= '0;
      cnt_wdata   <= '0;
      cnt_cfg_wr  <= 1'b0;
      cnt_rd_req  <= 1'b0;
      for (int i = 0; i < N_CH; i++) bank_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      samples_q   <= samples_d;
      cur_ch_q    <= cur_ch_d;
      tmo_q       <= tmo_d;
      stl_q       <= stl_d;
      tmo_flag_q  <= tmo_flag_d;
      abort_q     <= abort_d;
      busy        <= busy_d;
      sweep_irq   <= irq_d;
      res_valid   <= valid_d;
      res_timeout <= timeout_d;
      cnt_addr    <= addr_d;
      cnt_wdata   <= wdata_d;
      cnt_cfg_wr  <= cfg_wr_d;
      cnt_rd_req  <= rd_req_d;
      if (bank_we) bank_q[cur_ch_q] <= cnt_rdata[AVG_W-1:0];
    end
  end

endmodule

// File: tb/tb_freq_sweep_sequencer.sv
// Bench for the sweep sequencer: a behavioural frequency counter plus a
// per-sweep expectation of programming order, results and flags.
module tb_freq_sweep_sequencer;
  import freq_pkg::*;

  localparam int unsigned TB_TIMEOUT = 50;
  localparam int unsigned TB_SETTLE  = 4;

  logic        Clock = 1'b0;
  logic        nReset = 1'b0;
  logic        host_start = 1'b0, host_abort = 1'b0, host_ack = 1'b0;
  logic [31:0] host_mask = '0;
  logic [9:0]  host_samples = '0;
  logic        busy, sweep_irq;
  logic [4:0]  res_sel = '0;
  logic [9:0]  res_data;
  logic [31:0] res_valid, res_timeout;
  logic [5:0]  cnt_addr;
  logic [15:0] cnt_wdata;
  logic        cnt_cfg_wr, cnt_rd_req;
  logic [15:0] cnt_rdata;
  logic        cnt_irq;

  freq_sweep_sequencer #(
    .N_CH(32), .TIMEOUT_CYCLES(TB_TIMEOUT), .SETTLE_CYCLES(TB_SETTLE)
  ) dut (
    .Clock(Clock), .nReset(nReset), .host_start(host_start), .host_abort(host_abort),
    .host_mask(host_mask), .host_samples(host_samples), .busy(busy), .sweep_irq(sweep_irq),
    .host_ack(host_ack), .res_sel(res_sel), .res_data(res_data), .res_valid(res_valid),
    .res_timeout(res_timeout), .cnt_addr(cnt_addr), .cnt_wdata(cnt_wdata),
    .cnt_cfg_wr(cnt_cfg_wr), .cnt_rd_req(cnt_rd_req), .cnt_rdata(cnt_rdata), .cnt_irq(cnt_irq)
  );

  always #5 Clock = ~Clock;

  typedef struct packed { logic [5:0] addr; logic [15:0] data; } wr_t;
  typedef wr_t wr_q_t [$];

  // Behavioural counter: logs config writes, fires irq irq_delay cycles after
  // START (never if 0), returns the selected channel's average on read request.
  wr_t        wr_log [$];
  int         rd_count = 0;
  int         irq_delay = 10;
  logic [9:0] avg_tab [32];
  logic       irq_q, spurious = 1'b0;
  logic       run;
  int         cd;
  logic [4:0] sel_reg;

  assign cnt_irq = irq_q | spurious;

  always @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      irq_q <= 1'b0; run <= 1'b0; cd <= 0; sel_reg <= '0; cnt_rdata <= '0;
    end else begin
      if (cnt_cfg_wr) begin
        wr_log.push_back({cnt_addr, cnt_wdata});
        if (cnt_addr == ADDR_SEL) sel_reg <= cnt_wdata[4:0];
        if (cnt_addr == ADDR_START && irq_delay > 0) begin run <= 1'b1; cd <= irq_delay; end
      end else if (run) begin
        if (cd <= 1) begin irq_q <= 1'b1; run <= 1'b0; end
        else cd <= cd - 1;
      end
      if (cnt_rd_req) begin
        rd_count = rd_count + 1;
        cnt_rdata <= {6'($urandom), avg_tab[sel_reg]};
        irq_q <= 1'b0;
        run <= 1'b0;
      end
    end
  end

  int         checks = 0, failures = 0;
  logic [9:0] ref_bank [32];
  logic [9:0] bank_snap [32];

  // Expected counter programming for one full sweep: ascending channel order
  function automatic wr_q_t model_log(input logic [31:0] m, input logic [9:0] s);
    wr_q_t q;
    for (int ch = 0; ch < 32; ch++) begin
      if (m[ch]) begin
        q.push_back({ADDR_SEL, 16'(ch)});
        q.push_back({ADDR_SAMPLES, 16'(s)});
        q.push_back({ADDR_START, 16'h0000});
      end
    end
    return q;
  endfunction

  function automatic wr_t norm(input wr_t w);
    wr_t r = w;
    if (r.addr == ADDR_START) r.data = '0;
    return r;
  endfunction

  function automatic int popcount(input logic [31:0] m);
    int n = 0;
    for (int i = 0; i < 32; i++) if (m[i]) n++;
    return n;
  endfunction

  task automatic pulse_start(input logic [31:0] m, input logic [9:0] s);
    @(negedge Clock); host_mask = m; host_samples = s; host_start = 1'b1;
    @(negedge Clock); host_start = 1'b0;
  endtask

  task automatic pulse_ack();
    @(negedge Clock); host_ack = 1'b1;
    @(negedge Clock); host_ack = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int n = 0;
    while (busy === 1'b1 && n < budget) begin @(negedge Clock); n++; end
    ok = (busy === 1'b0);
  endtask

  task automatic read_bank();
    for (int i = 0; i < 32; i++) begin
      @(negedge Clock); res_sel = 5'(i); #1; bank_snap[i] = res_data;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge Clock);
    nReset = 1'b1;
    @(negedge Clock);
    checks++; if ({busy, sweep_irq, cnt_cfg_wr, cnt_rd_req} !== 4'b0) begin
      failures++; $display("FAIL reset_flags got=%b required=0000", {busy, sweep_irq, cnt_cfg_wr, cnt_rd_req}); end
    checks++; if ({res_valid, res_timeout} !== 64'h0) begin
      failures++; $display("FAIL reset_res got=%h required=0", {res_valid, res_timeout}); end
    checks++; if ({cnt_addr, cnt_wdata} !== 22'h0) begin
      failures++; $display("FAIL reset_cnt got=%h required=0", {cnt_addr, cnt_wdata}); end
    read_bank();
    foreach (bank_snap[i]) begin
      checks++; if (bank_snap[i] !== 10'h0) begin
        failures++; $display("FAIL reset_bank[%0d] got=%h required=000", i, bank_snap[i]); end
    end
  endtask

  // One sweep with mask/samples/delay, checked against the model
  task automatic sweep_and_check(input string name, input logic [31:0] m, input logic [9:0] s);
    wr_q_t exp;
    bit ok;
    int w0 = wr_log.size();
    int r0 = rd_count;
    pulse_start(m, s);
    wait_idle(4000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL %s_idle busy=%b required=0", name, busy); end
    for (int ch = 0; ch < 32; ch++) if (m[ch]) ref_bank[ch] = avg_tab[ch];
    exp = model_log(m, s);
    checks++;
    if (wr_log.size() - w0 !== exp.size()) begin
      failures++; $display("FAIL %s_wr_count got=%0d required=%0d", name, wr_log.size() - w0, exp.size());
    end else begin
      foreach (exp[i]) begin
        checks++; if (norm(wr_log[w0 + i]) !== norm(exp[i])) begin
          failures++; $display("FAIL %s_wr[%0d] got=%h required=%h", name, i, wr_log[w0 + i], exp[i]); end
      end
    end
    checks++; if (rd_count - r0 !== popcount(m)) begin
      failures++; $display("FAIL %s_rd_count got=%0d required=%0d", name, rd_count - r0, popcount(m)); end
    checks++; if (res_valid !== m) begin
      failures++; $display("FAIL %s_valid got=%h required=%h", name, res_valid, m); end
    checks++; if (res_timeout !== 32'h0) begin
      failures++; $display("FAIL %s_timeout got=%h required=0", name, res_timeout); end
    checks++; if (sweep_irq !== 1'b1) begin
      failures++; $display("FAIL %s_irq got=%b required=1", name, sweep_irq); end
    read_bank();
    foreach (bank_snap[i]) begin
      checks++; if (bank_snap[i] !== ref_bank[i]) begin
        failures++; $display("FAIL %s_bank[%0d] got=%h required=%h", name, i, bank_snap[i], ref_bank[i]); end
    end
  endtask

  task automatic test_basic();
    foreach (avg_tab[i]) avg_tab[i] = 10'($urandom);
    avg_tab[0] = 10'h155; avg_tab[2] = 10'h0AA;
    irq_delay = 40;
    sweep_and_check("basic", 32'h0000_0005, 10'd100);
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      logic [31:0] m = $urandom & $urandom & $urandom;
      if (m == 0) m = 32'h1 << $urandom_range(0, 31);
      foreach (avg_tab[i]) avg_tab[i] = 10'($urandom);
      irq_delay = $urandom_range(5, 40);
      pulse_ack();
      sweep_and_check("random", m, 10'($urandom));
    end
  endtask

  task automatic test_zero_mask();
    int w0, busy_cycles = 0;
    bit strobe = 1'b0, irq_seen = 1'b0;
    pulse_ack();
    w0 = wr_log.size();
    pulse_start(32'h0, 10'd7);
    for (int i = 0; i < 6; i++) begin
      if (busy) busy_cycles++;
      if (cnt_cfg_wr || cnt_rd_req) strobe = 1'b1;
      @(negedge Clock);
    end
    checks++; if (busy_cycles > 2 || busy !== 1'b0) begin
      failures++; $display("FAIL zero_busy got=%0d cycles (busy=%b) required<=2 and idle", busy_cycles, busy); end
    checks++; if (strobe !== 1'b0 || wr_log.size() !== w0) begin
      failures++; $display("FAIL zero_strobes got=%b writes=%0d required=0", strobe, wr_log.size() - w0); end
    checks++; if (sweep_irq !== 1'b1) begin
      failures++; $display("FAIL zero_irq got=%b required=1", sweep_irq); end
    // ack held high across the done cycle: the set must still be seen
    @(negedge Clock); host_ack = 1'b1; host_mask = '0; host_start = 1'b1;
    @(negedge Clock); host_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (sweep_irq) irq_seen = 1'b1;
      @(negedge Clock);
    end
    checks++; if (irq_seen !== 1'b1) begin
      failures++; $display("FAIL set_beats_ack got=%b required=1", irq_seen); end
    checks++; if (sweep_irq !== 1'b0) begin
      failures++; $display("FAIL ack_clears got=%b required=0", sweep_irq); end
    host_ack = 1'b0;
  endtask

  task automatic test_timeout();
    int n = 0;
    bit ok;
    pulse_ack();
    foreach (avg_tab[i]) avg_tab[i] = 10'($urandom);
    irq_delay = 0;
    pulse_start(32'h8000_0000, 10'd33);
    while (cnt_rd_req !== 1'b1 && n < 300) begin @(negedge Clock); n++; end
    checks++; if (n < TB_TIMEOUT || n > TB_TIMEOUT + 10) begin
      failures++; $display("FAIL timeout_latency got=%0d required=%0d..%0d", n, TB_TIMEOUT, TB_TIMEOUT + 10); end
    wait_idle(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL timeout_idle busy=%b required=0", busy); end
    ref_bank[31] = avg_tab[31];
    checks++; if (res_timeout !== 32'h8000_0000) begin
      failures++; $display("FAIL timeout_flag got=%h required=80000000", res_timeout); end
    checks++; if (res_valid !== 32'h0) begin
      failures++; $display("FAIL timeout_valid got=%h required=0", res_valid); end
    checks++; if (sweep_irq !== 1'b1) begin
      failures++; $display("FAIL timeout_irq got=%b required=1", sweep_irq); end
    @(negedge Clock); res_sel = 5'd31; #1;
    checks++; if (res_data !== ref_bank[31]) begin
      failures++; $display("FAIL timeout_bank got=%h required=%h", res_data, ref_bank[31]); end
    irq_delay = 10;
  endtask

  task automatic test_abort();
    int n = 0, w0, r0;
    bit ok;
    pulse_ack();
    foreach (avg_tab[i]) avg_tab[i] = 10'($urandom);
    irq_delay = 30;
    w0 = wr_log.size(); r0 = rd_count;
    @(negedge Clock); host_mask = 32'h7; host_samples = 10'd9; host_start = 1'b1;
    @(negedge Clock); host_start = 1'b0;
    while (wr_log.size() < w0 + 6 && n < 500) begin @(negedge Clock); n++; end
    irq_delay = 0;
    repeat (5) @(negedge Clock);
    host_abort = 1'b1;
    @(negedge Clock); host_abort = 1'b0;
    wait_idle(100, ok);
    ref_bank[0] = avg_tab[0];
    checks++; if (!ok) begin failures++; $display("FAIL abort_idle busy=%b required=0", busy); end
    checks++; if (rd_count - r0 !== 2) begin
      failures++; $display("FAIL abort_rd_count got=%0d required=2", rd_count - r0); end
    checks++; if (wr_log.size() - w0 !== 6) begin
      failures++; $display("FAIL abort_writes got=%0d required=6", wr_log.size() - w0); end
    checks++; if (sweep_irq !== 1'b0) begin
      failures++; $display("FAIL abort_irq got=%b required=0", sweep_irq); end
    checks++; if (res_valid !== 32'h1) begin
      failures++; $display("FAIL abort_valid got=%h required=00000001", res_valid); end
    @(negedge Clock); res_sel = 5'd0; #1;
    checks++; if (res_data !== ref_bank[0]) begin
      failures++; $display("FAIL abort_bank0 got=%h required=%h", res_data, ref_bank[0]); end
    irq_delay = 10;
  endtask

  task automatic test_reset_mid();
    int n = 0, w0;
    w0 = wr_log.size();
    irq_delay = 200;
    pulse_start(32'h0000_0010, 10'd5);
    while (wr_log.size() < w0 + 3 && n < 100) begin @(negedge Clock); n++; end
    repeat (5) @(negedge Clock);
    nReset = 1'b0;
    #1;
    checks++; if ({busy, sweep_irq, cnt_cfg_wr, cnt_rd_req} !== 4'b0) begin
      failures++; $display("FAIL rst_mid_flags got=%b required=0000", {busy, sweep_irq, cnt_cfg_wr, cnt_rd_req}); end
    checks++; if ({res_valid, res_timeout, cnt_addr, cnt_wdata} !== 86'h0) begin
      failures++; $display("FAIL rst_mid_regs got=%h required=0", {res_valid, res_timeout, cnt_addr, cnt_wdata}); end
    res_sel = 5'd4; #1;
    checks++; if (res_data !== 10'h0) begin
      failures++; $display("FAIL rst_mid_bank got=%h required=000", res_data); end
    foreach (ref_bank[i]) ref_bank[i] = '0;
    @(negedge Clock); nReset = 1'b1;
    repeat (3) @(negedge Clock);
    foreach (avg_tab[i]) avg_tab[i] = 10'($urandom);
    irq_delay = 15;
    sweep_and_check("rst_clean", 32'h0100_0012, 10'($urandom));
  endtask

  task automatic test_back_to_back();
    bit ok;
    wr_q_t exp;
    int w0, n = 0;
    logic [31:0] ma = 32'h0000_0003, mb = 32'h0000_00C0;
    pulse_ack();
    foreach (avg_tab[i]) avg_tab[i] = 10'($urandom);
    irq_delay = 20;
    w0 = wr_log.size();
    pulse_start(ma, 10'd11);
    repeat (10) @(negedge Clock);
    pulse_start(mb, 10'd22);
    wait_idle(2000, ok);
    ref_bank[0] = avg_tab[0]; ref_bank[1] = avg_tab[1];
    exp = model_log(ma, 10'd11);
    checks++; if (!ok || wr_log.size() - w0 !== exp.size()) begin
      failures++; $display("FAIL busy_start_ignored writes=%0d required=%0d", wr_log.size() - w0, exp.size()); end
    checks++; if (res_valid !== ma || sweep_irq !== 1'b1) begin
      failures++; $display("FAIL busy_start_result got=%h/%b required=%h/1", res_valid, sweep_irq, ma); end
    @(negedge Clock); host_mask = mb; host_samples = 10'd22; host_start = 1'b1; host_ack = 1'b1;
    @(negedge Clock); host_start = 1'b0; host_ack = 1'b0;
    checks++; if (sweep_irq !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL start_ack got irq=%b busy=%b required irq=0 busy=1", sweep_irq, busy); end
    w0 = wr_log.size();
    wait_idle(2000, ok);
    ref_bank[6] = avg_tab[6]; ref_bank[7] = avg_tab[7];
    checks++; if (!ok || res_valid !== mb || sweep_irq !== 1'b1) begin
      failures++; $display("FAIL start_ack_sweep got=%h/%b required=%h/1", res_valid, sweep_irq, mb); end
    read_bank();
    foreach (bank_snap[i]) begin
      checks++; if (bank_snap[i] !== ref_bank[i]) begin
        failures++; $display("FAIL b2b_bank[%0d] got=%h required=%h", i, bank_snap[i], ref_bank[i]); end
    end
    n = wr_log.size() - w0;
    checks++; if (n !== 6) begin failures++; $display("FAIL start_ack_writes got=%0d required=6", n); end
  endtask

  task automatic test_spurious_irq();
    int r0 = rd_count;
    bit strobe = 1'b0;
    pulse_ack();
    @(negedge Clock); spurious = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      if (cnt_rd_req || cnt_cfg_wr || busy) strobe = 1'b1;
    end
    spurious = 1'b0;
    checks++; if (strobe !== 1'b0 || rd_count !== r0) begin
      failures++; $display("FAIL spurious_irq got=%b reads=%0d required=0", strobe, rd_count - r0); end
  endtask

  initial begin
    foreach (ref_bank[i]) ref_bank[i] = '0;
    foreach (avg_tab[i]) avg_tab[i] = '0;
    test_reset();
    test_basic();
    test_random();
    test_zero_mask();
    test_timeout();
    test_abort();
    test_spurious_irq();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_time_limit got=expired required=finished");
    $fatal(1, "time limit");
  end

endmodule
